// File: rtl/mac_result_requant.sv
// mac_result_requant
//
// Captures one vector of per-row MAC accumulator results together with a
// per-row bias and a shift amount. Each row is requantized
// (bias add -> round half up -> arithmetic right shift -> saturate) and
// streamed out one row per cycle over a valid/ready interface.
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   mac_valid_i    result vector valid (sampled only while mac_ready_o)
//   mac_ready_o    block is idle and can take a vector
//   mac_result_i   packed signed results, row r at [r*DATA_WIDTH +: DATA_WIDTH]
//   bias_i         packed signed per-row bias, same packing
//   shift_i        right-shift amount; values above DATA_WIDTH clamp to DATA_WIDTH
//   out_valid_o    output row valid
//   out_ready_i    consumer accepts the row
//   out_data_o     requantized signed row value
//   out_row_o      row index of out_data_o
//   out_last_o     marks row ARRAY_ROWS-1
//   sat_o          sticky: some row of the current frame saturated
//
// state  | meaning
// IDLE   | waiting for a result vector, mac_ready_o high
// LOAD   | vector captured, computing row 0 into the output register
// STREAM | presenting rows, advancing one row per accepted handshake

module mac_result_requant #(
    parameter int DATA_WIDTH = 16,
    parameter int ARRAY_ROWS = 16,
    parameter int OUT_WIDTH  = 8,
    parameter int SHIFT_W    = 5,
    parameter int ROW_W      = $clog2(ARRAY_ROWS)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             mac_valid_i,
    output logic                             mac_ready_o,
    input  logic [ARRAY_ROWS*DATA_WIDTH-1:0] mac_result_i,
    input  logic [ARRAY_ROWS*DATA_WIDTH-1:0] bias_i,
    input  logic [SHIFT_W-1:0]               shift_i,
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic [OUT_WIDTH-1:0]             out_data_o,
    output logic [ROW_W-1:0]                 out_row_o,
    output logic                             out_last_o,
    output logic                             sat_o
);

    // Two guard bits: the bias sum plus the largest rounding constant
    // never overflows DATA_WIDTH+2 bits.
    localparam int SW = DATA_WIDTH + 2;

    localparam logic [ROW_W-1:0]      LAST_ROW  = ROW_W'(ARRAY_ROWS - 1);
    localparam logic [SHIFT_W-1:0]    SHIFT_MAX = SHIFT_W'(DATA_WIDTH);
    localparam logic signed [SW-1:0]  OUT_MAX   = SW'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0]  OUT_MIN   = SW'(-(2 ** (OUT_WIDTH - 1)));

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM
    } state_t;

    state_t state_q, state_d;

    logic [ARRAY_ROWS*DATA_WIDTH-1:0] res_q;
    logic [ARRAY_ROWS*DATA_WIDTH-1:0] bias_q;
    logic [SHIFT_W-1:0]               shift_q;

    logic capture;
    logic load_row;
    logic finish;

    logic [ROW_W-1:0]            sel_row;
    logic signed [DATA_WIDTH-1:0] x;
    logic signed [DATA_WIDTH-1:0] b;
    logic signed [SW-1:0]        sum;
    logic signed [SW-1:0]        rnd;
    logic signed [SW-1:0]        y;
    logic [OUT_WIDTH-1:0]        req_data;
    logic                        req_sat;

    assign mac_ready_o = (state_q == IDLE);

    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        load_row = 1'b0;
        finish   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mac_valid_i) begin
                    capture = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                load_row = 1'b1;
                state_d  = STREAM;
            end
            STREAM: begin
                if (out_valid_o && out_ready_i) begin
                    if (out_row_o == LAST_ROW) begin
                        finish  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        load_row = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // out_row_o doubles as the row counter; the next row to compute is
    // row 0 on entry and row+1 on every accepted handshake afterwards.
    assign sel_row = (state_q == LOAD) ? '0 : out_row_o + 1'b1;

    always_comb begin
        x   = res_q[sel_row*DATA_WIDTH +: DATA_WIDTH];
        b   = bias_q[sel_row*DATA_WIDTH +: DATA_WIDTH];
        sum = {{2{x[DATA_WIDTH-1]}}, x} + {{2{b[DATA_WIDTH-1]}}, b};
        rnd = '0;
        if (shift_q != '0) begin
            rnd = SW'(1) << (shift_q - 1'b1);
        end
        y        = (sum + rnd) >>> shift_q;
        req_data = y[OUT_WIDTH-1:0];
        req_sat  = 1'b0;
        if (y > OUT_MAX) begin
            req_data = OUT_MAX[OUT_WIDTH-1:0];
            req_sat  = 1'b1;
        end else if (y < OUT_MIN) begin
            req_data = OUT_MIN[OUT_WIDTH-1:0];
            req_sat  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q       <= '0;
            bias_q      <= '0;
            shift_q     <= '0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_row_o   <= '0;
            out_last_o  <= 1'b0;
            sat_o       <= 1'b0;
        end else begin
            if (capture) begin
                res_q     <= mac_result_i;
                bias_q    <= bias_i;
                shift_q   <= (shift_i > SHIFT_MAX) ? SHIFT_MAX : shift_i;
                out_row_o <= '0;
                sat_o     <= 1'b0;
            end
            if (load_row) begin
                out_valid_o <= 1'b1;
                out_data_o  <= req_data;
                out_row_o   <= sel_row;
                out_last_o  <= (sel_row == LAST_ROW);
                if (req_sat) begin
                    sat_o <= 1'b1;
                end
            end
            if (finish) begin
                out_valid_o <= 1'b0;
                out_last_o  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mac_result_requant.sv
module tb_mac_result_requant;

    localparam int DW  = 16;
    localparam int AR  = 16;
    localparam int OW  = 8;
    localparam int SWD = 5;
    localparam int RW  = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               mac_valid_i = 1'b0;
    logic               mac_ready_o;
    logic [AR*DW-1:0]   mac_result_i;
    logic [AR*DW-1:0]   bias_i;
    logic [SWD-1:0]     shift_i;
    logic               out_valid_o;
    logic               out_ready_i = 1'b1;
    logic [OW-1:0]      out_data_o;
    logic [RW-1:0]      out_row_o;
    logic               out_last_o;
    logic               sat_o;

    int res_v[AR];
    int bias_v[AR];
    int sh_v = 0;

    always #5 clk = ~clk;

    always_comb begin
        mac_result_i = '0;
        bias_i       = '0;
        for (int r = 0; r < AR; r++) begin
            mac_result_i[r*DW +: DW] = DW'(res_v[r]);
            bias_i[r*DW +: DW]       = DW'(bias_v[r]);
        end
        shift_i = SWD'(sh_v);
    end

    mac_result_requant #(
        .DATA_WIDTH(DW), .ARRAY_ROWS(AR), .OUT_WIDTH(OW), .SHIFT_W(SWD), .ROW_W(RW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .mac_valid_i(mac_valid_i), .mac_ready_o(mac_ready_o),
        .mac_result_i(mac_result_i), .bias_i(bias_i), .shift_i(shift_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .out_row_o(out_row_o),
        .out_last_o(out_last_o), .sat_o(sat_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Reference arithmetic straight from the requantization rules.
    function automatic int requant(int x, int b, int sh, output bit sat);
        int s;
        int y;
        int omax;
        int omin;
        omax = 2 ** (OW - 1) - 1;
        omin = -(2 ** (OW - 1));
        if (sh > DW) sh = DW;
        s = x + b;
        if (sh > 0) s = s + (1 << (sh - 1));
        y = s >>> sh;
        sat = 1'b0;
        if (y > omax) begin
            y = omax;
            sat = 1'b1;
        end else if (y < omin) begin
            y = omin;
            sat = 1'b1;
        end
        return y;
    endfunction

    typedef struct {
        int rw;
        int dat;
        bit lst;
        bit cum;
    } exp_t;

    exp_t exp_q[$];
    bit   exp_busy = 1'b0;
    bit   in_load  = 1'b0;
    bit   exp_sat  = 1'b0;
    int   cyc      = 0;
    int   n_cap    = 0;
    int   prev_cap = 0;
    int   last_cap = 0;
    int   frame_hs = 0;
    int   hs_last  = 0;
    int   got[AR];

    // Model: one frame of expectations is queued per accepted vector; one
    // entry is retired per expected handshake.
    always @(posedge clk) begin
        cyc++;
        if (rst_n) begin
            bit busy_pre;
            bit valid_pre;
            busy_pre  = exp_busy;
            valid_pre = exp_busy && !in_load;
            if (valid_pre && out_ready_i) begin
                got[exp_q[0].rw] = int'($signed(out_data_o));
                void'(exp_q.pop_front());
                frame_hs++;
                if (exp_q.size() == 0) begin
                    exp_busy = 1'b0;
                    hs_last  = frame_hs;
                end
            end
            in_load = 1'b0;
            if (mac_valid_i && !busy_pre) begin
                bit cum;
                bit s;
                int d;
                cum = 1'b0;
                for (int r = 0; r < AR; r++) begin
                    d = requant(res_v[r], bias_v[r], sh_v, s);
                    cum = cum | s;
                    exp_q.push_back('{rw: r, dat: d, lst: (r == AR - 1), cum: cum});
                end
                exp_busy = 1'b1;
                in_load  = 1'b1;
                exp_sat  = 1'b0;
                n_cap++;
                prev_cap = last_cap;
                last_cap = cyc;
                frame_hs = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            bit ev;
            ev = exp_busy && !in_load;
            if (ev) exp_sat = exp_q[0].cum;
            chk("mac_ready", int'(mac_ready_o), int'(!exp_busy));
            chk("out_valid", int'(out_valid_o), int'(ev));
            chk("sat", int'(sat_o), int'(exp_sat));
            if (ev) begin
                chk("out_data", int'($signed(out_data_o)), exp_q[0].dat);
                chk("out_row", int'(out_row_o), exp_q[0].rw);
                chk("out_last", int'(out_last_o), int'(exp_q[0].lst));
            end else begin
                chk("out_last_idle", int'(out_last_o), 0);
            end
        end
    end

    task automatic clear_vec();
        for (int r = 0; r < AR; r++) begin
            res_v[r]  = 0;
            bias_v[r] = 0;
        end
    endtask

    task automatic basic_vec();
        clear_vec();
        for (int r = 0; r < AR; r++) res_v[r] = 256 * r;
        sh_v = 2;
    endtask

    task automatic round_vec();
        clear_vec();
        res_v[0] = -3;
        res_v[1] = 3;
        res_v[2] = -4;
        res_v[3] = 5;
        sh_v = 1;
    endtask

    task automatic capture();
        int k;
        k = 0;
        while (!mac_ready_o && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!mac_ready_o) timeout("capture_ready");
        for (int r = 0; r < AR; r++) got[r] = -999;
        mac_valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mac_valid_i = 1'b0;
    endtask

    task automatic finish_frame();
        int k;
        k = 0;
        while (exp_busy && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (exp_busy) timeout("frame_end");
        chk("handshakes", hs_last, AR);
    endtask

    task automatic wait_row(int r);
        int k;
        k = 0;
        while (!(out_valid_o && int'(out_row_o) == r) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!(out_valid_o && int'(out_row_o) == r)) timeout("wait_row");
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_valid"}, int'(out_valid_o), 0);
        chk({tag, "_ready"}, int'(mac_ready_o), 1);
        chk({tag, "_sat"},   int'(sat_o), 0);
        chk({tag, "_data"},  int'(out_data_o), 0);
        chk({tag, "_row"},   int'(out_row_o), 0);
        chk({tag, "_last"},  int'(out_last_o), 0);
    endtask

    initial begin
        bit s;
        int k;
        int n0;

        clear_vec();
        #12;
        check_reset_outputs("reset");

        // Pin the model against hand-computed values.
        chk("pin_round_m3", requant(-3, 0, 1, s), -1);
        chk("pin_round_5", requant(5, 0, 1, s), 3);
        chk("pin_bias27", requant(100, 27, 0, s), 127);
        chk("pin_bias27_sat", int'(s), 0);
        chk("pin_bias28", requant(100, 28, 0, s), 127);
        chk("pin_bias28_sat", int'(s), 1);
        chk("pin_min", requant(-32768, 0, 0, s), -128);
        chk("pin_clamp", requant(32767, 32767, 31, s), 1);

        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic frame, ready high throughout.
        basic_vec();
        capture();
        k = 1;
        while (!mac_ready_o && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("ready_return_cycle", k, 18);
        finish_frame();
        chk("basic_row0", got[0], 0);
        chk("basic_row1", got[1], 64);
        chk("basic_row2", got[2], 127);
        chk("basic_row15", got[15], 127);
        chk("basic_sat", int'(sat_o), 1);

        // Backpressure on row 5.
        basic_vec();
        capture();
        wait_row(5);
        out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_valid", int'(out_valid_o), 1);
            chk("stall_row", int'(out_row_o), 5);
            chk("stall_data", int'($signed(out_data_o)), 127);
        end
        out_ready_i = 1'b1;
        finish_frame();

        // Rounding, with a new vector pulsed while streaming.
        round_vec();
        capture();
        wait_row(3);
        for (int r = 0; r < AR; r++) res_v[r] = 1000;
        mac_valid_i = 1'b1;
        @(negedge clk);
        mac_valid_i = 1'b0;
        finish_frame();
        chk("round_r0", got[0], -1);
        chk("round_r1", got[1], 2);
        chk("round_r2", got[2], -2);
        chk("round_r3", got[3], 3);
        chk("round_sat", int'(sat_o), 0);

        // Bias and saturation edges at shift 0.
        clear_vec();
        res_v[0] = 100; bias_v[0] = 27; sh_v = 0;
        capture();
        finish_frame();
        chk("bias27_out", got[0], 127);
        chk("bias27_sat", int'(sat_o), 0);

        clear_vec();
        res_v[0] = 100; bias_v[0] = 28; sh_v = 0;
        capture();
        finish_frame();
        chk("bias28_out", got[0], 127);
        chk("bias28_sat", int'(sat_o), 1);

        clear_vec();
        res_v[0] = -32768; sh_v = 0;
        capture();
        finish_frame();
        chk("min_out", got[0], -128);
        chk("min_sat", int'(sat_o), 1);

        // Oversized shift clamps to DATA_WIDTH.
        clear_vec();
        res_v[0] = 32767;  bias_v[0] = 32767;
        res_v[1] = -32768; bias_v[1] = -32768;
        res_v[3] = -1;
        sh_v = 31;
        capture();
        finish_frame();
        chk("clamp_r0", got[0], 1);
        chk("clamp_r1", got[1], -1);
        chk("clamp_r3", got[3], 0);

        // Back-to-back: valid held high with a second vector.
        n0 = n_cap;
        basic_vec();
        capture();
        mac_valid_i = 1'b1;
        round_vec();
        k = 0;
        while (n_cap < n0 + 2 && k < 100) begin
            @(negedge clk);
            k++;
        end
        mac_valid_i = 1'b0;
        if (n_cap < n0 + 2) timeout("second_capture");
        chk("b2b_period", last_cap - prev_cap, 18);
        chk("b2b_sat_cleared", int'(sat_o), 0);
        finish_frame();
        chk("b2b_r0", got[0], -1);
        chk("b2b_r3", got[3], 3);
        chk("b2b_sat", int'(sat_o), 0);

        // Reset during row 7.
        basic_vec();
        capture();
        wait_row(7);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        exp_busy = 1'b0;
        in_load  = 1'b0;
        exp_sat  = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        basic_vec();
        capture();
        finish_frame();
        chk("after_reset_r1", got[1], 64);
        chk("after_reset_r15", got[15], 127);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_result_requant.md
# mac_result_requant

Downstream stage of the PE core MAC array. Captures one full vector of per-row accumulator results, applies a per-row bias, a rounding arithmetic right shift and saturation to a narrow signed output, then streams the rows out one per cycle over a valid/ready interface. It decouples the MAC array, which produces all rows at once, from the row-serial writeback path.

## Interface
- DATA_WIDTH, 16: signed width of each MAC result and each bias.
- ARRAY_ROWS, 16: rows per result vector, ≥2.
- OUT_WIDTH, 8: signed output width, < DATA_WIDTH.
- SHIFT_W, 5: width of the shift amount.
- ROW_W, $clog2(ARRAY_ROWS): width of the row index.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mac_valid_i  in  1  result vector valid.
- mac_ready_o  out  1  block can accept a vector.
- mac_result_i  in  ARRAY_ROWS*DATA_WIDTH  signed results; row r at [r*DATA_WIDTH +: DATA_WIDTH].
- bias_i  in  ARRAY_ROWS*DATA_WIDTH  signed per-row bias, same packing.
- shift_i  in  SHIFT_W  right-shift amount, legal range 0..DATA_WIDTH.
- out_valid_o  out  1  output row valid.
- out_ready_i  in  1  consumer accepts the row.
- out_data_o  out  OUT_WIDTH  requantized signed row value.
- out_row_o  out  ROW_W  row index of out_data_o.
- out_last_o  out  1  high with row ARRAY_ROWS-1.
- sat_o  out  1  sticky: some row of the current frame saturated.

## Operation
- States are IDLE, LOAD and STREAM. mac_ready_o = (state==IDLE), decoded combinationally.
- **IDLE:** when mac_valid_i && mac_ready_o:
  - register all results, biases and shift_i;
  - clear row_cnt and sat_o;
  - go to LOAD.
  - mac_valid_i is ignored in every other state. Upstream holds data until the handshake.
- **LOAD:** compute row 0 into the output registers, set out_valid_o, go to STREAM.
- **STREAM:** on out_valid_o && out_ready_i:
  - If row_cnt==ARRAY_ROWS-1: clear out_valid_o and out_last_o, go to IDLE.
  - Otherwise: increment row_cnt and load the next row's result in the same edge, keeping out_valid_o high.
- **Backpressure:** while out_valid_o && !out_ready_i, out_data_o, out_row_o and out_last_o hold stable.
- **Arithmetic per row, with x = result and b = bias, both signed DATA_WIDTH:**
  - s = x + b, sign-extended to DATA_WIDTH+2 bits; the sum cannot overflow.
  - If shift>0: s = s + (1 << (shift-1)). This rounds half toward +infinity.
  - y = s >>> shift, arithmetic shift.
  - If y > 2^(OUT_WIDTH-1)-1: out = max positive and sat_o is set. If y < -2^(OUT_WIDTH-1): out = min negative and sat_o is set. Otherwise out = y[OUT_WIDTH-1:0].
  - shift_i > DATA_WIDTH is clamped to DATA_WIDTH.
- sat_o is set when a saturating row is loaded into the output register. It stays set until the next capture.
- **Reset values:** state=IDLE, mac_ready_o=1, out_valid_o=0, out_data_o=0, out_row_o=0, out_last_o=0, sat_o=0, captured registers=0.
- **Reset mid-frame:** the frame is abandoned. No further rows are emitted and outputs take their reset values immediately (asynchronous).

## Timing
- Capture handshake at edge E. out_valid_o rises after edge E+1 with row 0.
- With out_ready_i held high, rows 0..ARRAY_ROWS-1 are presented in the cycles after edges E+1..E+ARRAY_ROWS, one per cycle.
- mac_ready_o goes high after the edge of the last row's handshake. The next capture is possible in that same cycle.
- Minimum frame period is ARRAY_ROWS+2 cycles.
- out_valid_o never drops before its handshake.
- out_row_o increments by exactly 1 per handshake. out_last_o is only high when out_row_o==ARRAY_ROWS-1.

## Test plan
- **Basic frame:** row r = 256*r, bias 0, shift 2, out_ready_i high.
  - Rows 0..15 emit r*64 saturated: row 0=0, row 1=64, rows ≥2 = 127 (0x7F).
  - sat_o=1; out_last_o high only on row 15; mac_ready_o high again 18 cycles after capture.
- **Rounding:** shift 1 with results -3, 3, -4, 5 and bias 0. Expect -1, 2, -2, 3. sat_o=0.
- **Bias and saturation edges**, shift 0:
  - result 100, bias 27: out 127, sat_o=0.
  - result 100, bias 28: out 127, sat_o=1.
  - result 0x8000, bias 0: out 0x80 (-128), sat_o=1.
- **Backpressure:** drop out_ready_i for 3 cycles while row 5 is valid. Row 5's data, row index and valid hold stable. Exactly 16 handshakes occur with no duplicates or gaps.
- **Ignored input and back-to-back:**
  - Pulse mac_valid_i with new data during STREAM. The output is unchanged.
  - Hold mac_valid_i high with a second vector. It is captured in the cycle mac_ready_o returns high, and frame 2 begins with sat_o cleared.
- **Reset mid-frame:** assert rst_n low during row 7. out_valid_o=0, mac_ready_o=1 and sat_o=0 immediately. After release, a new frame streams from row 0.
